// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an L_DATA-cycle
// shift-add multiplier sharing one registered result/flag path.
module alu_seq #(
    parameter int L_DATA = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        ctrl,
    input  logic [L_DATA-1:0] op1,
    input  logic [L_DATA-1:0] op2,
    output logic [L_DATA-1:0] out,
    output logic              done,
    output logic              busy,
    output logic              zero,
    output logic              ovf
);
    localparam int CW = $clog2(L_DATA);

    typedef enum logic {IDLE, MUL} state_t;

    state_t              state, state_nxt;
    logic [2*L_DATA-1:0] mcand, acc, acc_sum;
    logic [L_DATA-1:0]   mlt;
    logic [CW-1:0]       cnt;
    logic                mul_last;
    logic [L_DATA-1:0]   res;
    logic                res_ovf;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_last  = (cnt == CW'(L_DATA - 1));
        case (state)
            IDLE: if (start && ctrl == 3'b111) state_nxt = MUL;
            MUL:  if (mul_last)                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Final iteration's add is folded into the value loaded into out.
    assign acc_sum = acc + (mlt[0] ? mcand : '0);
    assign busy    = (state == MUL);

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        case (ctrl)
            3'b000: res = op1;
            3'b001: {res_ovf, res} = {1'b0, op1} + {1'b0, op2};
            3'b010: begin
                res     = op1 - op2;
                res_ovf = (op1 < op2);
            end
            3'b011: res = op1 | op2;
            3'b100: res = op1 << op2;
            3'b101: res = op1 >> op2;
            3'b110: res = {{(L_DATA-1){1'b0}}, (op1 < op2)};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            zero  <= 1'b1;
            ovf   <= 1'b0;
            done  <= 1'b0;
            mcand <= '0;
            mlt   <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                if (ctrl != 3'b111) begin
                    out  <= res;
                    zero <= (res == '0);
                    ovf  <= res_ovf;
                    done <= 1'b1;
                end else begin
                    mcand <= {{L_DATA{1'b0}}, op1};
                    mlt   <= op2;
                    acc   <= '0;
                    cnt   <= '0;
                end
            end else if (state == MUL) begin
                acc   <= acc_sum;
                mcand <= mcand << 1;
                mlt   <= mlt >> 1;
                cnt   <= cnt + 1'b1;
                if (mul_last) begin
                    out  <= acc_sum[L_DATA-1:0];
                    zero <= (acc_sum[L_DATA-1:0] == '0);
                    ovf  <= |acc_sum[2*L_DATA-1:L_DATA];
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at L_DATA=16.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  ctrl = 3'b000;
    logic [15:0] op1 = '0, op2 = '0;
    logic [15:0] out;
    logic        done, busy, zero, ovf;
    int checks = 0;
    int errors = 0;

    alu_seq #(.L_DATA(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .op1(op1), .op2(op2),
        .out(out), .done(done), .busy(busy), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1; ctrl = c; op1 = a; op2 = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out !== 16'h0000 || zero !== 1'b1 || ovf !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: out=%h zero=%b ovf=%b done=%b busy=%b want 0000 1 0 0 0",
                         i, out, zero, ovf, done, busy);
            end
        end
    endtask

    task automatic test_add_sub();
        issue(3'b001, 16'hFFFF, 16'h0001);
        step();
        checks++;
        if (out !== 16'h0000 || zero !== 1'b1 || ovf !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL add_carry: out=%h zero=%b ovf=%b done=%b want 0000 1 1 1", out, zero, ovf, done);
        end
        issue(3'b010, 16'd3, 16'd5);
        step();
        checks++;
        if (out !== 16'hFFFE || zero !== 1'b0 || ovf !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL sub_borrow: out=%h zero=%b ovf=%b done=%b want fffe 0 1 1", out, zero, ovf, done);
        end
        start = 1'b0; ctrl = 3'b000; op1 = 16'h1111;
        step();
        checks++;
        if (out !== 16'hFFFE || ovf !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: out=%h ovf=%b done=%b want fffe 1 0", out, ovf, done);
        end
    endtask

    task automatic test_shift_cmp();
        logic [2:0]  vc [8];
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic [15:0] ve [8];
        vc = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b101, 3'b110, 3'b011, 3'b000};
        va = '{16'h0001, 16'h0001, 16'hABCD, 16'h8000, 16'hFFFF, 16'd2, 16'h00F0, 16'h1234};
        vb = '{16'd15, 16'd16, 16'd0, 16'd15, 16'd20, 16'd7, 16'h0F00, 16'hFFFF};
        ve = '{16'h8000, 16'h0000, 16'hABCD, 16'h0001, 16'h0000, 16'h0001, 16'h0FF0, 16'h1234};
        for (int i = 0; i < 8; i++) begin
            issue(vc[i], va[i], vb[i]);
            step();
            checks++;
            if (out !== ve[i] || zero !== (ve[i] == 16'h0) || ovf !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL shift_cmp[%0d] ctrl=%b: out=%h zero=%b ovf=%b done=%b want %h %b 0 1",
                         i, vc[i], out, zero, ovf, done, ve[i], (ve[i] == 16'h0));
            end
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_mul_ovf();
        issue(3'b111, 16'h0123, 16'h0100);
        step();
        // operands scrambled and a competing request held while busy
        issue(3'b001, 16'h0000, 16'h0000);
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || out !== 16'h1234) begin
                errors++;
                $display("FAIL mul_busy cyc%0d: busy=%b done=%b out=%h want 1 0 1234", i, busy, done, out);
            end
            if (i == 16) start = 1'b0;
            step();
        end
        checks++;
        if (out !== 16'h2300 || ovf !== 1'b1 || zero !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_ovf_done: out=%h ovf=%b zero=%b done=%b busy=%b want 2300 1 0 1 0",
                     out, ovf, zero, done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || out !== 16'h2300) begin
            errors++;
            $display("FAIL mul_done_pulse: done=%b out=%h want 0 2300", done, out);
        end
    endtask

    task automatic test_back_to_back();
        issue(3'b111, 16'd7, 16'd6);
        step();
        start = 1'b0;
        for (int i = 1; i < 17; i++) step();
        checks++;
        if (out !== 16'h002A || ovf !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_small: out=%h ovf=%b done=%b busy=%b want 002a 0 1 0", out, ovf, done, busy);
        end
        issue(3'b001, 16'h0010, 16'h0020);
        step();
        start = 1'b0;
        checks++;
        if (out !== 16'h0030 || ovf !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_add: out=%h ovf=%b done=%b busy=%b want 0030 0 1 0", out, ovf, done, busy);
        end
    endtask

    task automatic test_rst_abort();
        int seen_done;
        issue(3'b111, 16'h00FF, 16'h00FF);
        step();
        start = 1'b0;
        for (int i = 1; i < 5; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out !== 16'h0000 || zero !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: busy=%b out=%h zero=%b done=%b want 0 0000 1 0", busy, out, zero, done);
        end
        // reset wins over a simultaneous request
        issue(3'b001, 16'h0001, 16'h0001);
        step();
        start = 1'b0;
        rst = 1'b0;
        checks++;
        if (out !== 16'h0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: out=%h done=%b want 0000 0", out, done);
        end
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL no_done_after_abort: %0d cycles with done/busy high, want 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift_cmp();
        issue(3'b000, 16'h1234, 16'h0000);
        step();
        start = 1'b0;
        test_mul_ovf();
        test_back_to_back();
        test_rst_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter L_DATA, default 16, operand/result width in bits; legal range 4..64.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 ctrl  input  3  operation select; encodings in REQ-012.
REQ-006 op1  input  L_DATA  first operand, unsigned.
REQ-007 op2  input  L_DATA  second operand, unsigned.
REQ-008 out  output  L_DATA  registered result; holds the last result until the next done.
REQ-009 done  output  1  one-cycle pulse; out, zero and ovf are valid while it is high.
REQ-010 busy  output  1  high while a multiply iterates; start is ignored while high.
REQ-011 zero  output  1  registered, equals (out == 0); updated together with out.
REQ-011a ovf  output  1  registered overflow/carry flag; updated together with out.

Function
REQ-012 ctrl encodings: 000 pass op1; 001 op1+op2; 010 op1-op2; 011 op1|op2; 100 op1<<op2; 101 op1>>op2 (logical); 110 unsigned op1<op2 (out = 0 or 1); 111 unsigned multiply.
REQ-013 Control FSM has states IDLE and MUL; reset state IDLE.
REQ-014 IDLE with start=1 and ctrl!=111: result of REQ-012 is registered at that edge; at the same edge done is set to 1 for the next cycle; the FSM stays in IDLE.
REQ-015 Single-cycle ops have a latency of 1 clock, and back-to-back starts are accepted on every cycle.
REQ-016 IDLE with start=1 and ctrl=111: op1, op2 are latched, the accumulator is cleared, the FSM enters MUL, and busy=1 from the next cycle.
REQ-017 MUL performs one shift-add iteration per cycle for exactly L_DATA cycles: if multiplier LSB=1, the accumulator adds the multiplicand; the multiplicand shifts left 1 and the multiplier shifts right 1.
REQ-018 The edge ending the last MUL cycle loads out with the low L_DATA bits of the product, pulses done, clears busy, and returns the FSM to IDLE; total latency is L_DATA+1 clocks from the accepting edge.
REQ-019 Operands changing during MUL do not affect the result (latched copies only).
REQ-020 start is accepted in the cycle done=1 whenever busy=0, so a new request may follow completion with no gap.
REQ-021 Arithmetic wraps modulo 2^L_DATA.
REQ-022 ovf is set as follows:
- add: carry out.
- sub: borrow (op1<op2).
- multiply: product high half nonzero.
- all other operations: 0.
REQ-023 Shift amounts: op2 >= L_DATA yields out=0; op2=0 yields out=op1.
REQ-024 ctrl values are sampled only at acceptance; when no request is accepted, out, zero and ovf hold and done=0.
REQ-025 Accumulator width is 2*L_DATA so that ovf detection for multiply is exact.

Reset
REQ-026 While rst=1 at an edge:
- out=0, zero=1, ovf=0, done=0, busy=0.
- FSM=IDLE; internal operand/accumulator registers are cleared.
REQ-027 rst takes priority over start in the same cycle; the request is discarded.
REQ-028 rst during MUL aborts the multiply, and no done pulse is produced for it.

Verification (L_DATA=16)
REQ-029 Reset, then idle 3 cycles -> out=0x0000, zero=1, ovf=0, done=0, busy=0 throughout.
REQ-030 Add then sub:
- start, ctrl=001, op1=0xFFFF, op2=0x0001 -> next cycle out=0x0000, zero=1, ovf=1, done=1.
- start the following cycle, ctrl=010, op1=3, op2=5 -> next cycle out=0xFFFE, ovf=1.
REQ-031 Shift and compare:
- ctrl=100, op1=0x0001, op2=15 -> out=0x8000.
- op2=16 -> out=0x0000.
- ctrl=110, op1=2, op2=7 -> out=0x0001.
REQ-032 Multiply with overflow: ctrl=111, op1=0x0123, op2=0x0100, operands changed to 0 after acceptance ->
- busy=1 for 16 cycles.
- done on the 17th cycle after acceptance, with out=0x2300, ovf=1.
- start ignored while busy.
REQ-033 Multiply without overflow: ctrl=111, op1=7, op2=6 -> out=0x002A, ovf=0.
- A new start with ctrl=001 in the done cycle is accepted, and its result appears the next cycle.
REQ-034 rst=1 asserted 5 cycles into a multiply -> busy=0 and out=0 the next cycle, and no done pulse follows.
